xor_pulse_sched: RTL and testbench

XOR_PULSE_SCHED -- requirements
Module: xor_pulse_sched

---
 rtl/xor_pulse_sched.sv | 160 ++++++++++++++++
 tb/tb_xor_pulse_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_pulse_sched.sv
// xor_pulse_sched: arbitrates pulse requests on the a, b and clk lines of an
// XOR-type storage cell. Guard counters keep each line quiet long enough for
// the cell to settle. A mirror of the cell's stored value and its output
// level is maintained alongside.
module xor_pulse_sched #(
    parameter int T_DC   = 1,
    parameter int T_DD   = 3,
    parameter int T_SAME = 4,
    parameter int T_CD   = 5,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       req_clk,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       gnt_clk,
    output logic       pulse_a,
    output logic       pulse_b,
    output logic       pulse_clk,
    output logic [1:0] cell_state,
    output logic       exp_out,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_A     = 2'd1,
        ST_B     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] G_DC   = CNT_W'(T_DC);
    localparam logic [CNT_W-1:0] G_DD   = CNT_W'(T_DD);
    localparam logic [CNT_W-1:0] G_SAME = CNT_W'(T_SAME);
    localparam logic [CNT_W-1:0] G_CD   = CNT_W'(T_CD);
    localparam logic [CNT_W-1:0] G_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] G_ZERO = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] g_a, g_b, g_clk;
    logic [CNT_W-1:0] g_a_d, g_b_d, g_clk_d;
    logic             exp_d;
    logic             rr_b, rr_b_d;
    logic             el_a, el_b, el_clk;
    logic             sel_a, sel_b, sel_clk;

    // A guard load never shortens a wait that is already running.
    function automatic logic [CNT_W-1:0] guard_load(input logic [CNT_W-1:0] cur,
                                                    input logic [CNT_W-1:0] t);
        return (cur > t) ? cur : t;
    endfunction

    // Idle guards count down to zero and then hold.
    function automatic logic [CNT_W-1:0] guard_dec(input logic [CNT_W-1:0] cur);
        return (cur != G_ZERO) ? (cur - G_ONE) : G_ZERO;
    endfunction

    // Pick at most one eligible request: clk wins, then a/b by round robin.
    always_comb begin
        el_a    = req_a   && (g_a   == G_ZERO);
        el_b    = req_b   && (g_b   == G_ZERO);
        el_clk  = req_clk && (g_clk == G_ZERO);
        sel_clk = el_clk;
        sel_a   = !el_clk && el_a && (!el_b || !rr_b);
        sel_b   = !el_clk && el_b && (!el_a || rr_b);
    end

    // Next cell state, output level, guard values and round-robin pointer.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_out;
        rr_b_d  = rr_b;
        g_a_d   = guard_dec(g_a);
        g_b_d   = guard_dec(g_b);
        g_clk_d = guard_dec(g_clk);
        if (sel_clk) begin
            if (state_q == ST_A) begin
                exp_d   = ~exp_out;
                state_d = ST_EMPTY;
                g_b_d   = guard_load(g_b, G_CD);
            end else if (state_q == ST_B) begin
                exp_d   = ~exp_out;
                state_d = ST_EMPTY;
                g_a_d   = guard_load(g_a, G_CD);
            end
        end else if (sel_a) begin
            rr_b_d = 1'b1;
            case (state_q)
                ST_EMPTY: begin
                    state_d = ST_A;
                    g_clk_d = guard_load(g_clk, G_DC);
                end
                ST_A: begin
                    g_b_d   = guard_load(g_b, G_DD);
                    g_clk_d = guard_load(g_clk, G_DC);
                end
                ST_B: begin
                    state_d = ST_EMPTY;
                    g_a_d   = guard_load(g_a, G_SAME);
                end
                default: state_d = ST_EMPTY;
            endcase
        end else if (sel_b) begin
            rr_b_d = 1'b0;
            case (state_q)
                ST_EMPTY: begin
                    state_d = ST_B;
                    g_clk_d = guard_load(g_clk, G_DC);
                end
                ST_B: begin
                    g_a_d   = guard_load(g_a, G_DD);
                    g_clk_d = guard_load(g_clk, G_DC);
                end
                ST_A: begin
                    state_d = ST_EMPTY;
                    g_b_d   = guard_load(g_b, G_SAME);
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Register the grant decision together with its state and pulse effects.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            exp_out   <= 1'b0;
            rr_b      <= 1'b0;
            g_a       <= G_ZERO;
            g_b       <= G_ZERO;
            g_clk     <= G_ZERO;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            gnt_clk   <= 1'b0;
            pulse_a   <= 1'b0;
            pulse_b   <= 1'b0;
            pulse_clk <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_out   <= exp_d;
            rr_b      <= rr_b_d;
            g_a       <= g_a_d;
            g_b       <= g_b_d;
            g_clk     <= g_clk_d;
            gnt_a     <= sel_a;
            gnt_b     <= sel_b;
            gnt_clk   <= sel_clk;
            pulse_a   <= pulse_a ^ sel_a;
            pulse_b   <= pulse_b ^ sel_b;
            pulse_clk <= pulse_clk ^ sel_clk;
        end
    end

    assign cell_state = state_q;
    assign busy = (g_a != G_ZERO) || (g_b != G_ZERO) || (g_clk != G_ZERO)
                  || (state_q != ST_EMPTY);

endmodule

// File: tb/tb_xor_pulse_sched.sv
// tb_xor_pulse_sched: directed scenarios followed by random request traffic,
// every cycle compared against a behavioural model of the cell scheduler.
module tb_xor_pulse_sched;

    localparam int T_DC   = 1;
    localparam int T_DD   = 3;
    localparam int T_SAME = 4;
    localparam int T_CD   = 5;
    localparam int CNT_W  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic       req_clk = 1'b0;
    logic       gnt_a, gnt_b, gnt_clk;
    logic       pulse_a, pulse_b, pulse_clk;
    logic [1:0] cell_state;
    logic       exp_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = a, 1 = b, 2 = clk; state 0 empty, 1 a, 2 b.
    int m_g[3];
    int m_state;
    bit m_exp;
    bit m_pulse[3];
    bit m_gnt[3];
    int m_ptr;

    xor_pulse_sched #(
        .T_DC(T_DC), .T_DD(T_DD), .T_SAME(T_SAME), .T_CD(T_CD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .req_clk(req_clk),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_clk(gnt_clk),
        .pulse_a(pulse_a), .pulse_b(pulse_b), .pulse_clk(pulse_clk),
        .cell_state(cell_state), .exp_out(exp_out), .busy(busy)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Advance the model by one rising edge using the request levels present.
    task automatic model_update();
        int ng[3];
        bit el[3];
        bit r[3];
        int sel;
        int d;
        int o;
        r = '{req_a, req_b, req_clk};
        if (rst) begin
            m_g = '{0, 0, 0};
            m_state = 0;
            m_exp = 0;
            m_pulse = '{0, 0, 0};
            m_gnt = '{0, 0, 0};
            m_ptr = 0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            el[i] = r[i] && (m_g[i] == 0);
            ng[i] = (m_g[i] > 0) ? m_g[i] - 1 : 0;
            m_gnt[i] = 0;
        end
        sel = -1;
        if (el[2]) sel = 2;
        else if (el[0] && el[1]) sel = m_ptr;
        else if (el[0]) sel = 0;
        else if (el[1]) sel = 1;
        if (sel == 2) begin
            if (m_state != 0) begin
                m_exp = !m_exp;
                ng[2 - m_state] = imax(m_g[2 - m_state], T_CD);
                m_state = 0;
            end
        end else if (sel >= 0) begin
            d = sel;
            o = 1 - sel;
            if (m_state == 0) begin
                m_state = d + 1;
                ng[2] = imax(m_g[2], T_DC);
            end else if (m_state == d + 1) begin
                ng[o] = imax(m_g[o], T_DD);
                ng[2] = imax(m_g[2], T_DC);
            end else begin
                m_state = 0;
                ng[d] = imax(m_g[d], T_SAME);
            end
            m_ptr = o;
        end
        if (sel >= 0) begin
            m_gnt[sel] = 1;
            m_pulse[sel] = !m_pulse[sel];
        end
        m_g = ng;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Compare every DUT output with the model after the edge has settled.
    task automatic check_output();
        logic [7:0] eg;
        logic [7:0] ep;
        logic       eb;
        eg = {5'd0, m_gnt[2], m_gnt[1], m_gnt[0]};
        ep = {5'd0, m_pulse[2], m_pulse[1], m_pulse[0]};
        eb = (m_g[0] != 0) || (m_g[1] != 0) || (m_g[2] != 0) || (m_state != 0);
        check("gnt",   {5'd0, gnt_clk, gnt_b, gnt_a}, eg);
        check("pulse", {5'd0, pulse_clk, pulse_b, pulse_a}, ep);
        check("cell_state", {6'd0, cell_state}, 8'(m_state));
        check("exp_out", {7'd0, exp_out}, {7'd0, m_exp});
        check("busy", {7'd0, busy}, {7'd0, eb});
        check("gnt_onehot", {7'd0, $onehot0({gnt_clk, gnt_b, gnt_a})}, 8'd1);
        check("state_not3", {7'd0, cell_state != 2'd3}, 8'd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        check_output();
    endtask

    // Requester behaviour: drop a request once granted, randomly raise new ones.
    task automatic apply_stimulus();
        if (rst) begin
            rst = 1'b0;
        end else if ($urandom_range(249) == 0) begin
            rst = 1'b1;
        end
        if (m_gnt[0]) req_a = 1'b0;
        else if (!req_a && $urandom_range(3) == 0) req_a = 1'b1;
        else if (req_a && $urandom_range(39) == 0) req_a = 1'b0;
        if (m_gnt[1]) req_b = 1'b0;
        else if (!req_b && $urandom_range(3) == 0) req_b = 1'b1;
        else if (req_b && $urandom_range(39) == 0) req_b = 1'b0;
        if (m_gnt[2]) req_clk = 1'b0;
        else if (!req_clk && $urandom_range(4) == 0) req_clk = 1'b1;
        else if (req_clk && $urandom_range(39) == 0) req_clk = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        req_clk = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int gcount;
        m_g = '{0, 0, 0};
        m_state = 0;
        m_exp = 0;
        m_pulse = '{0, 0, 0};
        m_gnt = '{0, 0, 0};
        m_ptr = 0;

        $display("[TB] reset state");
        do_reset();
        check("rst_cell_state", {6'd0, cell_state}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);

        $display("[TB] a then clk");
        req_a = 1'b1;
        cycle();
        check("first_gnt_a", {7'd0, gnt_a}, 8'd1);
        req_a = 1'b0;
        req_clk = 1'b1;
        cycle();
        check("clk_guarded", {7'd0, gnt_clk}, 8'd0);
        cycle();
        check("clk_fires", {7'd0, gnt_clk}, 8'd1);
        check("exp_after_clk", {7'd0, exp_out}, 8'd1);
        req_clk = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        $display("[TB] clk held in empty state");
        req_clk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("clk_every_cycle", {7'd0, gnt_clk}, 8'd1);
        end
        req_clk = 1'b0;
        cycle();

        $display("[TB] a and b held together");
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        cycle();
        check("ab_first_a", {6'd0, gnt_b, gnt_a}, 8'd1);
        cycle();
        check("ab_then_b", {6'd0, gnt_b, gnt_a}, 8'd2);
        check("ab_state_empty", {6'd0, cell_state}, 8'd0);
        for (int i = 0; i < 10; i++) cycle();
        req_a = 1'b0;
        req_b = 1'b0;
        cycle();

        $display("[TB] b withheld by guard");
        do_reset();
        req_a = 1'b1; cycle(); req_a = 1'b0;
        req_b = 1'b1; cycle(); req_b = 1'b0;
        req_a = 1'b1; cycle(); req_a = 1'b0;
        req_b = 1'b1;
        gcount = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (gnt_b) gcount++;
            if (m_gnt[1]) req_b = 1'b0;
        end
        check("b_single_grant", 8'(gcount), 8'd1);

        $display("[TB] reset over eligible b");
        do_reset();
        req_b = 1'b1; cycle(); req_b = 1'b0;
        cycle();
        req_b = 1'b1;
        rst = 1'b1;
        cycle();
        check("rst_blocks_gnt_b", {7'd0, gnt_b}, 8'd0);
        check("rst_outputs", {gnt_a, gnt_b, gnt_clk, pulse_a, pulse_b, pulse_clk, exp_out, busy}, 8'd0);
        rst = 1'b0;
        req_b = 1'b0;

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            cycle();
            apply_stimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
